// File: rtl/mem_scan_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_scan_display_pkg
// Description : Shared FSM states, active-low seven-segment glyphs and lookup.
// Revision    : 1.0
// ============================================================================
package mem_scan_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // Active-low, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_H0 = 7'h40;
    localparam logic [6:0] SEG_H1 = 7'h79;
    localparam logic [6:0] SEG_H2 = 7'h24;
    localparam logic [6:0] SEG_H3 = 7'h30;
    localparam logic [6:0] SEG_H4 = 7'h19;
    localparam logic [6:0] SEG_H5 = 7'h12;
    localparam logic [6:0] SEG_H6 = 7'h02;
    localparam logic [6:0] SEG_H7 = 7'h78;
    localparam logic [6:0] SEG_H8 = 7'h00;
    localparam logic [6:0] SEG_H9 = 7'h10;
    localparam logic [6:0] SEG_HA = 7'h08;
    localparam logic [6:0] SEG_HB = 7'h03;
    localparam logic [6:0] SEG_HC = 7'h46;
    localparam logic [6:0] SEG_HD = 7'h21;
    localparam logic [6:0] SEG_HE = 7'h06;
    localparam logic [6:0] SEG_HF = 7'h0E;

    localparam logic [6:0] SEG_LA = ~7'h77;
    localparam logic [6:0] SEG_LB = ~7'h7C;
    localparam logic [6:0] SEG_LC = ~7'h39;
    localparam logic [6:0] SEG_LD = ~7'h5E;
    localparam logic [6:0] SEG_LE = ~7'h79;
    localparam logic [6:0] SEG_LF = ~7'h71;
    localparam logic [6:0] SEG_LG = ~7'h3D;
    localparam logic [6:0] SEG_LH = ~7'h76;
    localparam logic [6:0] SEG_LI = ~7'h30;
    localparam logic [6:0] SEG_LJ = ~7'h1E;
    localparam logic [6:0] SEG_LK = ~7'h75;
    localparam logic [6:0] SEG_LL = ~7'h38;
    localparam logic [6:0] SEG_LM = ~7'h37;
    localparam logic [6:0] SEG_LN = ~7'h54;
    localparam logic [6:0] SEG_LO = ~7'h5C;
    localparam logic [6:0] SEG_LP = ~7'h73;
    localparam logic [6:0] SEG_LQ = ~7'h67;
    localparam logic [6:0] SEG_LR = ~7'h50;
    localparam logic [6:0] SEG_LS = ~7'h6D;
    localparam logic [6:0] SEG_LT = ~7'h78;
    localparam logic [6:0] SEG_LU = ~7'h3E;
    localparam logic [6:0] SEG_LV = ~7'h1C;
    localparam logic [6:0] SEG_LW = ~7'h2A;
    localparam logic [6:0] SEG_LX = ~7'h76;
    localparam logic [6:0] SEG_LY = ~7'h6E;
    localparam logic [6:0] SEG_LZ = ~7'h5B;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_H0;
            4'h1: seg = SEG_H1;
            4'h2: seg = SEG_H2;
            4'h3: seg = SEG_H3;
            4'h4: seg = SEG_H4;
            4'h5: seg = SEG_H5;
            4'h6: seg = SEG_H6;
            4'h7: seg = SEG_H7;
            4'h8: seg = SEG_H8;
            4'h9: seg = SEG_H9;
            4'hA: seg = SEG_HA;
            4'hB: seg = SEG_HB;
            4'hC: seg = SEG_HC;
            4'hD: seg = SEG_HD;
            4'hE: seg = SEG_HE;
            default: seg = SEG_HF;
        endcase
        return seg;
    endfunction

    // Offset from 'A'/'a'; upper and lower case share one glyph set
    function automatic logic [6:0] letter_glyph(input logic [7:0] off);
        logic [6:0] seg;
        seg = SEG_DASH;
        case (off)
            8'd0:  seg = SEG_LA;
            8'd1:  seg = SEG_LB;
            8'd2:  seg = SEG_LC;
            8'd3:  seg = SEG_LD;
            8'd4:  seg = SEG_LE;
            8'd5:  seg = SEG_LF;
            8'd6:  seg = SEG_LG;
            8'd7:  seg = SEG_LH;
            8'd8:  seg = SEG_LI;
            8'd9:  seg = SEG_LJ;
            8'd10: seg = SEG_LK;
            8'd11: seg = SEG_LL;
            8'd12: seg = SEG_LM;
            8'd13: seg = SEG_LN;
            8'd14: seg = SEG_LO;
            8'd15: seg = SEG_LP;
            8'd16: seg = SEG_LQ;
            8'd17: seg = SEG_LR;
            8'd18: seg = SEG_LS;
            8'd19: seg = SEG_LT;
            8'd20: seg = SEG_LU;
            8'd21: seg = SEG_LV;
            8'd22: seg = SEG_LW;
            8'd23: seg = SEG_LX;
            8'd24: seg = SEG_LY;
            8'd25: seg = SEG_LZ;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    function automatic logic [6:0] glyph_lookup(input logic [7:0] code, input logic letter);
        logic [6:0] seg;
        seg = SEG_DASH;
        if (!letter) begin
            seg = hex_glyph(code[3:0]);
        end else if (code >= 8'h41 && code <= 8'h5A) begin
            seg = letter_glyph(code - 8'h41);
        end else if (code >= 8'h61 && code <= 8'h7A) begin
            seg = letter_glyph(code - 8'h61);
        end else if (code >= 8'h30 && code <= 8'h39) begin
            seg = hex_glyph(4'(code - 8'h30));
        end
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_glyph.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph
// Description : Combinational nibble / ASCII code to active-low segment map.
// Revision    : 1.0
// ============================================================================
module seg7_glyph
    import mem_scan_display_pkg::*;
(
    input  logic [7:0] i_code,
    input  logic       i_letter,
    output logic [6:0] o_seg
);

    assign o_seg = glyph_lookup(i_code, i_letter);

endmodule
`default_nettype wire

// File: rtl/mem_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : mem_scan_display
// Description : Steps through a memory window and shows the held word on a
//               multiplexed seven-segment display (hex or ASCII letter).
// Revision    : 1.0
// ============================================================================
module mem_scan_display
    import mem_scan_display_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int NUM_DIGITS  = 4,
    parameter int BASE_ADDR   = 0,
    parameter int WORDS       = 16,
    parameter int RD_LAT      = 0,
    parameter int REFRESH_DIV = 50000,
    parameter int AUTO_DIV    = 50000000,
    localparam int PAGE_W     = ((DATA_W / (NUM_DIGITS * 4)) > 1) ?
                                $clog2(DATA_W / (NUM_DIGITS * 4)) : 1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  auto_en,
    input  logic                  letter_mode,
    input  logic [PAGE_W-1:0]     page,
    input  logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     addr,
    output logic [6:0]            segments,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  word_valid
);

    localparam int AUTO_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [ADDR_W-1:0] c_FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(BASE_ADDR + WORDS - 1);
    localparam logic [AUTO_W-1:0] c_AUTO_MAX   = AUTO_W'(AUTO_DIV - 1);
    localparam logic [REF_W-1:0]  c_REF_MAX    = REF_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0]  c_DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [1:0]        c_RD_LAT     = 2'(RD_LAT);

    logic                  r_step_meta;
    logic                  r_step_sync;
    logic                  r_step_prev;
    logic                  r_man_pulse;
    logic [AUTO_W-1:0]     r_auto_cnt;
    logic                  r_auto_pulse;
    state_t                r_state;
    logic [1:0]            r_wait_cnt;
    logic                  r_pending;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_hold;
    logic                  r_valid;
    logic [REF_W-1:0]      r_ref_cnt;
    logic [DIG_W-1:0]      r_digit;
    logic [6:0]            r_segments;
    logic [NUM_DIGITS-1:0] r_digit_en;

    logic                  w_advance;
    logic [ADDR_W-1:0]     w_addr_next;
    logic [31:0]           w_shift_amt;
    logic [3:0]            w_nibble;
    logic [7:0]            w_code;
    logic [6:0]            w_glyph;
    logic [6:0]            w_seg_next;

    // The step button is asynchronous; the edge pulse is registered so it
    // lands three cycles after the button rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_meta <= 1'b0;
            r_step_sync <= 1'b0;
            r_step_prev <= 1'b0;
            r_man_pulse <= 1'b0;
        end else begin
            r_step_meta <= step;
            r_step_sync <= r_step_meta;
            r_step_prev <= r_step_sync;
            r_man_pulse <= r_step_sync & ~r_step_prev;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !auto_en) begin
            r_auto_cnt   <= '0;
            r_auto_pulse <= 1'b0;
        end else if (r_auto_cnt == c_AUTO_MAX) begin
            r_auto_cnt   <= '0;
            r_auto_pulse <= 1'b1;
        end else begin
            r_auto_cnt   <= r_auto_cnt + AUTO_W'(1);
            r_auto_pulse <= 1'b0;
        end
    end

    assign w_advance   = r_man_pulse | r_auto_pulse;
    assign w_addr_next = (r_addr == c_LAST_ADDR) ? c_FIRST_ADDR : r_addr + ADDR_W'(1);

    // An advance in IDLE is taken even if pending is also set: the two merge,
    // because advances arriving while pending is set are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= 2'd0;
            r_pending  <= 1'b0;
            r_addr     <= c_FIRST_ADDR;
            r_hold     <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_advance || r_pending) begin
                        r_addr     <= w_addr_next;
                        r_valid    <= 1'b0;
                        r_pending  <= 1'b0;
                        r_wait_cnt <= 2'd0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_advance) begin
                        r_pending <= 1'b1;
                    end
                    if (r_wait_cnt == c_RD_LAT) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                ST_CAPTURE: begin
                    if (w_advance) begin
                        r_pending <= 1'b1;
                    end
                    r_hold  <= rdata;
                    r_valid <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_shift_amt = (32'(page) * 32'(NUM_DIGITS) + 32'(r_digit)) << 2;
    assign w_nibble    = 4'(r_hold >> w_shift_amt);
    assign w_code      = letter_mode ? r_hold[7:0] : {4'h0, w_nibble};

    seg7_glyph u_glyph (
        .i_code   (w_code),
        .i_letter (letter_mode),
        .o_seg    (w_glyph)
    );

    always_comb begin
        w_seg_next = w_glyph;
        if (!r_valid) begin
            w_seg_next = SEG_DASH;
        end else if (letter_mode && (r_digit != '0)) begin
            w_seg_next = SEG_BLANK;
        end
    end

    // r_digit names the digit lit in the next slot, so the first slot is digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref_cnt  <= '0;
            r_digit    <= '0;
            r_segments <= SEG_BLANK;
            r_digit_en <= '1;
        end else if (r_ref_cnt == c_REF_MAX) begin
            r_ref_cnt  <= '0;
            r_segments <= w_seg_next;
            r_digit_en <= ~(NUM_DIGITS'(1) << r_digit);
            r_digit    <= (r_digit == c_DIG_LAST) ? '0 : r_digit + DIG_W'(1);
        end else begin
            r_ref_cnt <= r_ref_cnt + REF_W'(1);
        end
    end

    assign addr       = r_addr;
    assign segments   = r_segments;
    assign digit_en   = r_digit_en;
    assign word_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_scan_display
// Description : Directed self-checking bench for mem_scan_display.
// Revision    : 1.0
// ============================================================================
module tb_mem_scan_display;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 32;
    localparam int NUM_DIGITS  = 4;
    localparam int WORDS       = 4;
    localparam int RD_LAT      = 1;
    localparam int REFRESH_DIV = 4;
    localparam int AUTO_DIV    = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              step = 1'b0;
    logic              auto_en = 1'b0;
    logic              letter_mode = 1'b0;
    logic [0:0]        page = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr;
    logic [6:0]        segments;
    logic [3:0]        digit_en;
    logic              word_valid;

    logic [DATA_W-1:0] mem [0:255];
    logic [DATA_W-1:0] rd_q;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // One-cycle registered read honours RD_LAT = 1
    always @(posedge clk) rd_q <= mem[addr];
    assign rdata = rd_q;

    mem_scan_display #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_DIGITS  (NUM_DIGITS),
        .BASE_ADDR   (0),
        .WORDS       (WORDS),
        .RD_LAT      (RD_LAT),
        .REFRESH_DIV (REFRESH_DIV),
        .AUTO_DIV    (AUTO_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .step        (step),
        .auto_en     (auto_en),
        .letter_mode (letter_mode),
        .page        (page),
        .rdata       (rdata),
        .addr        (addr),
        .segments    (segments),
        .digit_en    (digit_en),
        .word_valid  (word_valid)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick(1);
        step = 1'b0;
    endtask

    // Waits for a fresh scan slot of digit k and returns its segments
    task automatic sample_digit(input int k, output logic [6:0] seg, output bit ok);
        logic [3:0] tgt;
        int n;
        tgt = ~(4'b0001 << k);
        n = 0;
        while (digit_en == tgt && n < 100) begin tick(1); n++; end
        while (digit_en != tgt && n < 100) begin tick(1); n++; end
        ok  = (digit_en == tgt);
        seg = segments;
    endtask

    task automatic test_reset();
        logic [6:0] exp_d [4];
        logic [6:0] seg;
        bit ok;
        exp_d = '{7'h19, 7'h30, 7'h24, 7'h79};
        reset = 1'b1;
        tick(3);
        checks++;
        if (segments !== 7'h7F) begin failures++; $display("FAIL reset_segments: got %h expected 7f", segments); end
        checks++;
        if (digit_en !== 4'hF) begin failures++; $display("FAIL reset_digit_en: got %h expected f", digit_en); end
        checks++;
        if (addr !== 8'h00 || word_valid !== 1'b0) begin
            failures++; $display("FAIL reset_state: got addr=%h valid=%b expected addr=00 valid=0", addr, word_valid);
        end
        reset = 1'b0;
        tick(2);
        checks++;
        if (word_valid !== 1'b0) begin failures++; $display("FAIL valid_cycle2: got %b expected 0", word_valid); end
        tick(1);
        checks++;
        if (word_valid !== 1'b1 || addr !== 8'h00) begin
            failures++; $display("FAIL valid_cycle3: got valid=%b addr=%h expected valid=1 addr=00", word_valid, addr);
        end
        for (int k = 0; k < 4; k++) begin
            sample_digit(k, seg, ok);
            checks++;
            if (!ok || seg !== exp_d[k]) begin
                failures++; $display("FAIL hex_digit%0d: got %h (slot_ok=%0d) expected %h", k, seg, ok, exp_d[k]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ea;
        for (int i = 0; i < 4; i++) begin
            pulse_step();
            tick(99);
            ea = 8'((i + 1) % 4);
            checks++;
            if (addr !== ea || word_valid !== 1'b1) begin
                failures++; $display("FAIL wrap_step%0d: got addr=%h valid=%b expected addr=%h valid=1", i, addr, word_valid, ea);
            end
        end
    endtask

    task automatic test_letter_and_page();
        logic [6:0] seg;
        bit ok;
        pulse_step();
        tick(20);
        checks++;
        if (addr !== 8'h01 || word_valid !== 1'b1) begin
            failures++; $display("FAIL letter_fetch: got addr=%h valid=%b expected addr=01 valid=1", addr, word_valid);
        end
        letter_mode = 1'b1;
        sample_digit(0, seg, ok);
        checks++;
        if (!ok || seg !== 7'h08) begin failures++; $display("FAIL letter_A: got %h expected 08", seg); end
        sample_digit(1, seg, ok);
        checks++;
        if (!ok || seg !== 7'h7F) begin failures++; $display("FAIL letter_blank1: got %h expected 7f", seg); end
        sample_digit(3, seg, ok);
        checks++;
        if (!ok || seg !== 7'h7F) begin failures++; $display("FAIL letter_blank3: got %h expected 7f", seg); end
        pulse_step();
        tick(20);
        sample_digit(0, seg, ok);
        checks++;
        if (addr !== 8'h02 || !ok || seg !== 7'h3F) begin
            failures++; $display("FAIL letter_other: got addr=%h seg=%h expected addr=02 seg=3f", addr, seg);
        end
        pulse_step();
        tick(20);
        letter_mode = 1'b0;
        page = 1'b1;
        sample_digit(0, seg, ok);
        checks++;
        if (addr !== 8'h03 || !ok || seg !== 7'h21) begin
            failures++; $display("FAIL page1_digit0: got addr=%h seg=%h expected addr=03 seg=21", addr, seg);
        end
        sample_digit(3, seg, ok);
        checks++;
        if (!ok || seg !== 7'h08) begin failures++; $display("FAIL page1_digit3: got %h expected 08", seg); end
        page = 1'b0;
        sample_digit(0, seg, ok);
        checks++;
        if (!ok || seg !== 7'h00) begin failures++; $display("FAIL page0_digit0: got %h expected 00", seg); end
        sample_digit(2, seg, ok);
        checks++;
        if (!ok || seg !== 7'h02) begin failures++; $display("FAIL page0_digit2: got %h expected 02", seg); end
    endtask

    // Three step edges two cycles apart: first in IDLE, second pends, third dropped
    task automatic test_back_to_back();
        step = 1'b1; tick(1);
        step = 1'b0; tick(1);
        step = 1'b1; tick(1);
        step = 1'b0; tick(1);
        step = 1'b1; tick(1);
        step = 1'b0;
        checks++;
        if (addr !== 8'h00 || word_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_first: got addr=%h valid=%b expected addr=00 valid=0", addr, word_valid);
        end
        tick(30);
        checks++;
        if (addr !== 8'h01 || word_valid !== 1'b1) begin
            failures++; $display("FAIL b2b_final: got addr=%h valid=%b expected addr=01 valid=1", addr, word_valid);
        end
    endtask

    task automatic test_auto_coincident();
        auto_en = 1'b1;
        tick(7);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(4);
        auto_en = 1'b0;
        checks++;
        if (addr !== 8'h02) begin failures++; $display("FAIL auto_coincide: got addr=%h expected 02", addr); end
        tick(20);
        checks++;
        if (addr !== 8'h02 || word_valid !== 1'b1) begin
            failures++; $display("FAIL auto_single: got addr=%h valid=%b expected addr=02 valid=1", addr, word_valid);
        end
    endtask

    task automatic test_reset_mid_fetch();
        step = 1'b1; tick(1);
        step = 1'b0; tick(1);
        step = 1'b1; tick(1);
        step = 1'b0;
        tick(3);
        checks++;
        if (addr !== 8'h03 || word_valid !== 1'b0) begin
            failures++; $display("FAIL midfetch_pre: got addr=%h valid=%b expected addr=03 valid=0", addr, word_valid);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (addr !== 8'h00 || word_valid !== 1'b0) begin
            failures++; $display("FAIL midfetch_reset: got addr=%h valid=%b expected addr=00 valid=0", addr, word_valid);
        end
        tick(1);
        reset = 1'b0;
        tick(20);
        checks++;
        if (addr !== 8'h00 || word_valid !== 1'b1) begin
            failures++; $display("FAIL midfetch_pending: got addr=%h valid=%b expected addr=00 valid=1", addr, word_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 32'h0000_1234;
        mem[1] = 32'h0000_0041;
        mem[2] = 32'h0000_0025;
        mem[3] = 32'hABCD_5678;
        test_reset();
        test_wrap();
        test_letter_and_page();
        test_back_to_back();
        test_auto_coincident();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
